// File: rtl/fuzz_drv_pkg.sv
// Shared types and helpers for the fuzz vector driver: FSM state encoding,
// default Galois taps and MISR start value, and the single-step LFSR function.
// Imported by fuzz_lfsr32 and fuzz_vector_driver.
package fuzz_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] DEF_TAPS     = 32'h80200003;
  localparam logic [31:0] DEF_SIG_INIT = 32'hFFFFFFFF;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x, input logic [31:0] taps);
    return (x >> 1) ^ (x[0] ? taps : 32'h0);
  endfunction

endpackage

// File: rtl/fuzz_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and step enable; load wins over enable.
// Latency: q updates one edge after load/en. No backpressure of its own (en is the stall).
// Ports: clk, rst_n (async active-low), load/load_val, en, q (current value, 0 in reset).
module fuzz_lfsr32
  import fuzz_drv_pkg::*;
#(
  parameter logic [31:0] TAPS = DEF_TAPS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        en,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= lfsr_step(q, TAPS);
    end
  end

endmodule

// File: rtl/fuzz_vector_driver.sv
// Fuzz stimulus driver: streams LFSR words to a DUT and folds its responses into a MISR.
// Latency: first vector valid one edge after start; each response folded RESP_LAT edges after its accept.
// Backpressure: stim_data holds while stim_valid & !stim_ready; the response pipe never stalls.
// Ports: clkin_data (bit 0 clock, bit 32 async active-low reset), start/seed/vec_count,
//        stim_data/stim_valid/stim_ready, resp_data/resp_probe, busy/done/signature/vec_idx.
// Build option: FUZZ_PROBE_CAPTURE_EN also folds a halfword-swapped resp_probe into the MISR.
module fuzz_vector_driver
  import fuzz_drv_pkg::*;
#(
  parameter int          RESP_LAT = 1,
  parameter logic [31:0] SIG_INIT = DEF_SIG_INIT,
  parameter logic [31:0] TAPS     = DEF_TAPS
) (
  input  logic [63:0] clkin_data,
  input  logic        start,
  input  logic [31:0] seed,
  input  logic [15:0] vec_count,
  output logic [31:0] stim_data,
  output logic        stim_valid,
  input  logic        stim_ready,
  input  logic [31:0] resp_data,
  input  logic [31:0] resp_probe,
  output logic        busy,
  output logic        done,
  output logic [31:0] signature,
  output logic [15:0] vec_idx
);

  // Pipe holding only its top bit means the final outstanding response is being folded.
  localparam logic [RESP_LAT-1:0] PIPE_LAST = RESP_LAT'(1) << (RESP_LAT - 1);

  logic                clk;
  logic                rst_n;
  state_t              state;
  state_t              state_nxt;
  logic [15:0]         remaining;
  logic [RESP_LAT-1:0] flag_pipe;
  logic [31:0]         lfsr_q;
  logic [31:0]         fold_value;
  logic                start_ok;
  logic                accept;
  logic                last_accept;
  logic                fold_en;
  logic                last_fold;

  assign clk   = clkin_data[0];
  assign rst_n = clkin_data[32];

  assign start_ok    = start && ((state == IDLE) || (state == DONE));
  assign stim_valid  = (state == RUN);
  assign accept      = stim_valid && stim_ready;
  assign last_accept = accept && (remaining == 16'd1);
  assign fold_en     = flag_pipe[RESP_LAT-1];
  assign last_fold   = (state == DRAIN) && (flag_pipe == PIPE_LAST);

  assign stim_data = lfsr_q;
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);

`ifdef FUZZ_PROBE_CAPTURE_EN
  assign fold_value = lfsr_step(signature, TAPS) ^ resp_data
                    ^ {resp_probe[15:0], resp_probe[31:16]};
`else
  assign fold_value = lfsr_step(signature, TAPS) ^ resp_data;
`endif

  // A zero seed would lock the LFSR, so it is replaced with 1.
  fuzz_lfsr32 #(
    .TAPS (TAPS)
  ) u_stim_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_ok),
    .load_val ((seed == 32'h0) ? 32'h1 : seed),
    .en       (accept),
    .q        (lfsr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (vec_count == 16'd0) ? DONE : RUN;
      RUN:        if (last_accept) state_nxt = DRAIN;
      DRAIN:      if (last_fold) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signature <= '0;
      vec_idx   <= '0;
      remaining <= '0;
      flag_pipe <= '0;
    end else begin
      // Responses are free-running relative to accepts, so the pipe shifts every edge.
      flag_pipe <= (flag_pipe << 1) | RESP_LAT'(accept);
      if (start_ok) begin
        signature <= SIG_INIT;
        vec_idx   <= '0;
        remaining <= vec_count;
      end else begin
        if (accept) begin
          vec_idx   <= vec_idx + 16'd1;
          remaining <= remaining - 16'd1;
        end
        if (fold_en) begin
          signature <= fold_value;
        end
      end
    end
  end

endmodule

// File: tb/tb_fuzz_vector_driver.sv
// Self-checking bench for fuzz_vector_driver: directed scenarios plus randomized runs,
// checked against a transaction-level model (expected vector sequence, accept count,
// per-edge response fold timeline).
module tb_fuzz_vector_driver;

  localparam int          LAT  = 1;
  localparam logic [31:0] POLY = 32'h80200003;
  localparam logic [31:0] SIG0 = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] clkin_data;
  logic        start;
  logic [31:0] seed;
  logic [15:0] vec_count;
  logic [31:0] stim_data;
  logic        stim_valid;
  logic        stim_ready;
  logic [31:0] resp_data;
  logic [31:0] resp_probe;
  logic        busy;
  logic        done;
  logic [31:0] signature;
  logic [15:0] vec_idx;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [31:0] m_vec;
  logic [31:0] m_sig;
  int          m_acc, m_total, m_folds;
  bit          m_active, m_done;
  bit          hist[$];
  logic [31:0] acc_q[$];
  int          cyc, done_at;
  bit          prev_stall;
  logic [31:0] prev_data;
  bit          resp_zero = 0;
  bit          probe_fixed = 0;

  assign clkin_data = {31'h0, rst_n, 31'h0, clk};
  always #5 clk = ~clk;

  fuzz_vector_driver #(.RESP_LAT(LAT)) dut (
    .clkin_data (clkin_data),
    .start      (start),
    .seed       (seed),
    .vec_count  (vec_count),
    .stim_data  (stim_data),
    .stim_valid (stim_valid),
    .stim_ready (stim_ready),
    .resp_data  (resp_data),
    .resp_probe (resp_probe),
    .busy       (busy),
    .done       (done),
    .signature  (signature),
    .vec_idx    (vec_idx)
  );

  function automatic logic [31:0] rstep(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
  endfunction

  function automatic logic [31:0] fold_fn(input logic [31:0] s, input logic [31:0] r,
                                          input logic [31:0] p);
`ifdef FUZZ_PROBE_CAPTURE_EN
    return rstep(s) ^ r ^ {p[15:0], p[31:16]};
`else
    return rstep(s) ^ r ^ (p & 32'h0);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_hist();
    hist.delete();
    for (int i = 0; i < LAT; i++) hist.push_back(1'b0);
  endtask

  task automatic drive_resp();
    resp_data  = resp_zero ? 32'h0 : $urandom;
    resp_probe = probe_fixed ? 32'h00010000 : $urandom;
  endtask

  task automatic model_reset();
    m_vec = 0; m_sig = 0; m_acc = 0; m_total = 0; m_folds = 0;
    m_active = 0; m_done = 0; prev_stall = 0;
    reset_hist();
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_sig"},  signature, m_sig);
    chk({tag, "_idx"},  32'(vec_idx), 32'(m_acc));
    chk({tag, "_done"}, 32'(done), 32'(m_done));
    chk({tag, "_busy"}, 32'(busy), 32'(m_active && !m_done));
  endtask

  // One clock: check pre-edge outputs, advance the model across the edge, check post-edge.
  task automatic cycle();
    bit          acc, fold, exp_vld;
    logic [31:0] r, p;
    exp_vld = m_active && (m_acc < m_total);
    chk("stim_valid", 32'(stim_valid), 32'(exp_vld));
    if (exp_vld) chk("stim_data", stim_data, m_vec);
    if (prev_stall) chk("stim_hold", stim_data, prev_data);
    acc        = exp_vld && stim_ready;
    prev_stall = stim_valid && !stim_ready;
    prev_data  = stim_data;
    fold       = hist.pop_front();
    hist.push_back(acc);
    r = resp_data;
    p = resp_probe;
    @(posedge clk); #1;
    cyc++;
    if (acc) begin
      acc_q.push_back(m_vec);
      m_vec = rstep(m_vec);
      m_acc++;
    end
    if (fold) begin
      m_sig = fold_fn(m_sig, r, p);
      m_folds++;
      if (m_folds == m_total) m_done = 1;
    end
    if (done === 1'b1 && done_at < 0) done_at = cyc;
    check_regs("cyc");
    drive_resp();
  endtask

  task automatic do_start(input logic [31:0] s, input logic [15:0] c);
    start = 1'b1; seed = s; vec_count = c; stim_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; seed = $urandom; vec_count = 16'($urandom);
    m_vec = (s == 32'h0) ? 32'h1 : s;
    m_sig = SIG0; m_acc = 0; m_total = int'(c); m_folds = 0;
    m_active = (c != 0); m_done = (c == 0);
    reset_hist(); acc_q.delete();
    cyc = 0; done_at = -1; prev_stall = 0;
    check_regs("start");
    drive_resp();
  endtask

  // mode 0: ready=1, mode 1: ready pattern 1,0,0,..., mode 2: random ready
  task automatic run(input int mode);
    int i = 0;
    while (!m_done && i < 2000) begin
      case (mode)
        0:       stim_ready = 1'b1;
        1:       stim_ready = (i % 3 == 0);
        default: stim_ready = 1'($urandom_range(0, 1));
      endcase
      cycle();
      i++;
    end
    chk("run_done", 32'(done), 32'd1);
  endtask

  initial begin
    int g;
    start = 0; seed = 0; vec_count = 0; stim_ready = 0; resp_data = 0; resp_probe = 0;
    model_reset();
    #12;
    chk("rst_stim_data", stim_data, 32'h0);
    chk("rst_valid", 32'(stim_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_sig", signature, 32'h0);
    chk("rst_idx", 32'(vec_idx), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: seed=1, three vectors, ready=1
    do_start(32'h1, 16'd3);
    run(0);
    chk("t1_v0", (acc_q.size() > 0) ? acc_q[0] : 32'hx, 32'h00000001);
    chk("t1_v1", (acc_q.size() > 1) ? acc_q[1] : 32'hx, 32'h80200003);
    chk("t1_v2", (acc_q.size() > 2) ? acc_q[2] : 32'hx, 32'hC0300002);
    chk("t1_idx", 32'(vec_idx), 32'd3);
    chk("t1_done_lat", 32'(done_at), 32'd4);

    // 2: zero seed, one vector, zero response
    resp_zero = 1; drive_resp();
    do_start(32'h0, 16'd1);
    run(0);
    chk("t2_v0", (acc_q.size() > 0) ? acc_q[0] : 32'hx, 32'h00000001);
    chk("t2_sig", signature, 32'hFFDFFFFC);
    resp_zero = 0;

    // 3: empty run
    do_start($urandom, 16'd0);
    chk("t3_done", 32'(done), 32'd1);
    stim_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("t3_sig", signature, 32'hFFFFFFFF);

    // 4: stalls with ready 1,0,0,1,...
    do_start($urandom, 16'd4);
    run(1);
    chk("t4_idx", 32'(vec_idx), 32'd4);
    stim_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    chk("t4_idx_after", 32'(vec_idx), 32'd4);
    chk("t4_accepts", 32'(acc_q.size()), 32'd4);

    // 5: asynchronous reset just after the 2nd of 8 accepts
    do_start($urandom, 16'd8);
    stim_ready = 1'b1;
    g = 0;
    while (m_acc < 2 && g < 50) begin cycle(); g++; end
    chk("t5_reached", 32'(vec_idx), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_stim_data", stim_data, 32'h0);
    chk("t5_valid", 32'(stim_valid), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_done", 32'(done), 32'h0);
    chk("t5_sig", signature, 32'h0);
    chk("t5_idx", 32'(vec_idx), 32'h0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_regs("t5_idle");
    do_start(32'h1, 16'd3);
    run(0);
    chk("t5_v0", (acc_q.size() > 0) ? acc_q[0] : 32'hx, 32'h00000001);
    chk("t5_v1", (acc_q.size() > 1) ? acc_q[1] : 32'hx, 32'h80200003);
    chk("t5_v2", (acc_q.size() > 2) ? acc_q[2] : 32'hx, 32'hC0300002);

`ifdef FUZZ_PROBE_CAPTURE_EN
    // 6: probe folded with halfword swap
    resp_zero = 1; probe_fixed = 1; drive_resp();
    do_start(32'h1, 16'd1);
    run(0);
    chk("t6_sig", signature, 32'hFFDFFFFD);
    resp_zero = 0; probe_fixed = 0;
`endif

    // randomized runs: random seed, length, ready and responses
    for (int k = 0; k < 8; k++) begin
      do_start((k == 0) ? 32'h0 : $urandom, 16'($urandom_range(1, 20)));
      run(2);
      chk("rnd_idx", 32'(vec_idx), 32'(m_total));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
